// File: rtl/skew_stream_pkg.sv
// Shared types and helpers for the skew-stream ping-pong A-edge memory.
// Provides the default element type, the stream FSM state encoding and the
// wavefront counter width helper used by the top and the bank sub-module.
package skew_stream_pkg;

  localparam int unsigned DEF_BITS_AB = 8;
  localparam int unsigned DEF_DIM     = 8;

  // Signed matrix element at the default width.
  typedef logic signed [DEF_BITS_AB-1:0] elem_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Width of the wavefront index t in 0 .. 2*dim-2.
  function automatic int unsigned wf_width(input int unsigned dim);
    return $clog2(2 * dim - 1);
  endfunction

endpackage

// File: rtl/skew_bank.sv
// One DIM x DIM matrix bank: row write port, full flag with set/clear, and a
// combinational skewed read returning wavefront t (lane i = M[i][t-i] or 0).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (clears full only)
//   we, row, din    write din into row 'row' (row already range-checked)
//   set_full        commit: mark bank full
//   clr_full        release: mark bank empty
//   t               wavefront index to read
//   full            bank holds a committed matrix
//   skew            lane outputs for wavefront t
module skew_bank
  import skew_stream_pkg::*;
#(
  parameter int unsigned DIM     = DEF_DIM,
  parameter int unsigned BITS_AB = DEF_BITS_AB,
  localparam int unsigned AW     = $clog2(DIM),
  localparam int unsigned TW     = wf_width(DIM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [AW-1:0]                 row,
  input  logic [DIM-1:0][BITS_AB-1:0]   din,
  input  logic                          set_full,
  input  logic                          clr_full,
  input  logic [TW-1:0]                 t,
  output logic                          full,
  output logic [DIM-1:0][BITS_AB-1:0]   skew
);

  logic [DIM-1:0][BITS_AB-1:0] mem [DIM];

  // Matrix storage; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[row] <= din;
    end
  end

  // Full flag; set and clear never target the same bank in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clr_full) begin
      full <= 1'b0;
    end
  end

  // Diagonal read: lane i sees column t-i when it lies inside the matrix.
  always_comb begin
    skew = '0;
    for (int i = 0; i < int'(DIM); i++) begin
      if ((int'(t) >= i) && ((int'(t) - i) < int'(DIM))) begin
        skew[i] = mem[AW'(i)][AW'(int'(t) - i)];
      end
    end
  end

endmodule

// File: rtl/skew_stream_pp.sv
// Double-buffered skew-stream memory for the A (row) edge of the systolic
// array. Host loads rows into the write bank and commits it; the read bank
// streams its matrix one diagonal wavefront per enabled cycle, with
// zero-bubble hand-over to the other bank when it is already full.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   WrEn, Arow, Ain    row write into the current write bank
//   wr_commit          mark write bank full and swap write bank
//   wr_ready           write bank is empty (combinational from registers)
//   en                 stream advance; low stalls
//   Aout, Avalid       registered skewed lanes and advance strobe
//   done               pulse with the final wavefront of a matrix
//   busy               stream FSM is in STREAM
module skew_stream_pp
  import skew_stream_pkg::*;
#(
  parameter int unsigned BITS_AB = DEF_BITS_AB,
  parameter int unsigned DIM     = DEF_DIM
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          WrEn,
  input  logic [$clog2(DIM)-1:0]        Arow,
  input  logic [DIM-1:0][BITS_AB-1:0]   Ain,
  input  logic                          wr_commit,
  output logic                          wr_ready,
  input  logic                          en,
  output logic [DIM-1:0][BITS_AB-1:0]   Aout,
  output logic                          Avalid,
  output logic                          done,
  output logic                          busy
);

  localparam int unsigned AW     = $clog2(DIM);
  localparam int unsigned TW     = wf_width(DIM);
  localparam logic [TW-1:0] T_LAST = TW'(2 * DIM - 2);

  state_e                      state, state_d;
  logic [TW-1:0]               t, t_d, t_rd;
  logic                        rd_bank, rd_bank_d;
  logic                        wr_bank;
  logic [DIM-1:0][BITS_AB-1:0] aout_d, skew_sel;
  logic                        avalid_d, done_d, busy_d;
  logic                        release_rd;
  logic                        row_ok, wr_acc, commit_acc;
  logic [1:0]                  full, we_b, set_b, clr_b;
  logic [DIM-1:0][BITS_AB-1:0] skew_b [2];

  // Write-side acceptance; out-of-range rows only exist for non-power-of-2 DIM.
  assign wr_ready   = ~full[wr_bank];
  assign row_ok     = (32'(Arow) < DIM);
  assign wr_acc     = WrEn && wr_ready && row_ok;
  assign commit_acc = wr_commit && wr_ready;

  // Per-bank write/commit/release steering.
  always_comb begin
    we_b  = '0;
    set_b = '0;
    clr_b = '0;
    for (int b = 0; b < 2; b++) begin
      we_b[b]  = wr_acc     && (wr_bank == 1'(b));
      set_b[b] = commit_acc && (wr_bank == 1'(b));
      clr_b[b] = release_rd && (rd_bank == 1'(b));
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    skew_bank #(
      .DIM     (DIM),
      .BITS_AB (BITS_AB)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we_b[b]),
      .row      (Arow),
      .din      (Ain),
      .set_full (set_b[b]),
      .clr_full (clr_b[b]),
      .t        (t_rd),
      .full     (full[b]),
      .skew     (skew_b[b])
    );
  end

  // In IDLE the next presentation is always wavefront 0.
  assign t_rd     = (state == STREAM) ? t : '0;
  assign skew_sel = skew_b[rd_bank];

  // Stream FSM next-state and registered-output values.
  always_comb begin
    state_d    = state;
    t_d        = t;
    rd_bank_d  = rd_bank;
    aout_d     = Aout;
    avalid_d   = 1'b0;
    done_d     = 1'b0;
    release_rd = 1'b0;
    case (state)
      IDLE: begin
        if (en && full[rd_bank]) begin
          aout_d   = skew_sel;
          avalid_d = 1'b1;
          t_d      = TW'(1);
          state_d  = STREAM;
        end else begin
          aout_d = '0;
          t_d    = '0;
        end
      end
      STREAM: begin
        if (en) begin
          aout_d   = skew_sel;
          avalid_d = 1'b1;
          if (t == T_LAST) begin
            done_d     = 1'b1;
            release_rd = 1'b1;
            rd_bank_d  = ~rd_bank;
            t_d        = '0;
            state_d    = IDLE;
          end else begin
            t_d = t + TW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == STREAM);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      t       <= '0;
      rd_bank <= 1'b0;
      wr_bank <= 1'b0;
      Aout    <= '0;
      Avalid  <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      t       <= t_d;
      rd_bank <= rd_bank_d;
      wr_bank <= commit_acc ? ~wr_bank : wr_bank;
      Aout    <= aout_d;
      Avalid  <= avalid_d;
      done    <= done_d;
      busy    <= busy_d;
    end
  end

endmodule
